// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/rvalid handshake,
// and applies the control unit's PCSrc redirect when the instruction retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        MisalignErr,
    output logic [31:0] RetireCount
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {BOOT, FETCH, WAIT, EXEC, HALT} state_t;

    state_t      state, state_next;
    logic [31:0] target;
    logic        aligned;
    logic        retire;

    always_comb begin
        target = PCPlus4;
        unique case (PCSrc)
            2'b00:   target = PCPlus4;
            2'b01:   target = PC + ImmExt;
            default: target = ALUResult & ~32'h0000_0001;
        endcase
    end

    assign aligned = (target[1:0] == 2'b00);
    assign retire  = (state == EXEC) && !Stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   state_next = WAIT;
            WAIT:    if (imem_rvalid) state_next = EXEC;
            EXEC:    if (!Stall) state_next = aligned ? FETCH : HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        imem_req   = (state == FETCH);
        InstrValid = (state == EXEC);
    end

    assign imem_addr = PC;
    assign PCPlus4   = PC + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC          <= RESET_PC;
            Instr       <= NOP;
            MisalignErr <= 1'b0;
            RetireCount <= '0;
        end else begin
            if (state == WAIT && imem_rvalid)
                Instr <= imem_rdata;
            // A misaligned target halts without touching PC or the retire count.
            if (retire) begin
                if (aligned) begin
                    PC          <= target;
                    RetireCount <= RetireCount + 32'd1;
                end else begin
                    MisalignErr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        MisalignErr;
    logic [31:0] RetireCount;

    int checks   = 0;
    int failures = 0;
    int lat      = 1;
    int cnt      = 0;
    logic [31:0] req_addr;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .ImmExt(ImmExt),
        .ALUResult(ALUResult), .Stall(Stall), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instr(Instr), .InstrValid(InstrValid), .PC(PC), .PCPlus4(PCPlus4),
        .MisalignErr(MisalignErr), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    // Memory answers lat cycles after the FETCH cycle; lat=1 means rvalid in the first WAIT cycle.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(req_addr);
            end
        end
        if (imem_req) begin
            cnt      = lat;
            req_addr = imem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !InstrValid; i++) @(negedge clk);
        check("valid_tmo", {31'b0, InstrValid}, 32'd1);
    endtask

    task automatic do_exec(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
        wait_valid();
        PCSrc     = src;
        ImmExt    = imm;
        ALUResult = alu;
        Stall     = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; Stall = 1'b0; PCSrc = 2'b00; ImmExt = '0; ALUResult = '0;
        imem_rvalid = 1'b0; imem_rdata = '0; req_addr = '0;
        @(negedge clk); @(negedge clk);
        check("rst_pc",    PC, 32'h100);
        check("rst_pc4",   PCPlus4, 32'h104);
        check("rst_instr", Instr, 32'h13);
        check("rst_valid", {31'b0, InstrValid}, 0);
        check("rst_req",   {31'b0, imem_req}, 0);
        check("rst_err",   {31'b0, MisalignErr}, 0);
        check("rst_cnt",   RetireCount, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("boot_req",  {31'b0, imem_req}, 1);
        check("boot_addr", imem_addr, 32'h100);
        @(negedge clk);
        check("wait_req",   {31'b0, imem_req}, 0);
        check("wait_valid", {31'b0, InstrValid}, 0);
        @(negedge clk);
        check("first_valid", {31'b0, InstrValid}, 1);
        check("first_instr", Instr, word(32'h100));

        do_exec(2'b00, '0, '0);
        check("seq_req",  {31'b0, imem_req}, 1);
        check("seq_addr", imem_addr, 32'h104);
        check("seq_pc4",  PCPlus4, 32'h108);
        check("seq_cnt",  RetireCount, 1);

        do_exec(2'b10, '0, 32'h200);
        check("jalr200_pc", PC, 32'h200);
        do_exec(2'b01, 32'hFFFF_FFF8, '0);
        check("br_back_pc",  PC, 32'h1F8);
        check("br_back_cnt", RetireCount, 3);
        do_exec(2'b10, '0, 32'h301);
        check("jalr_b0_pc",  PC, 32'h300);
        check("jalr_b0_err", {31'b0, MisalignErr}, 0);
        do_exec(2'b11, '0, 32'h200);
        check("jalr11_pc",  PC, 32'h200);
        check("jalr11_cnt", RetireCount, 5);

        wait_valid();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_pc",    PC, 32'h200);
            check("stall_instr", Instr, word(32'h200));
            check("stall_cnt",   RetireCount, 5);
            check("stall_valid", {31'b0, InstrValid}, 1);
        end
        lat = 5;
        do_exec(2'b00, '0, '0);
        check("unstall_pc",  PC, 32'h204);
        check("unstall_cnt", RetireCount, 6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_instr", Instr, word(32'h200));
            check("bp_valid", {31'b0, InstrValid}, 0);
        end
        @(negedge clk);
        check("bp_valid_late", {31'b0, InstrValid}, 1);
        check("bp_instr_late", Instr, word(32'h204));
        lat = 1;

        do_exec(2'b10, '0, 32'hFFFF_FFFC);
        check("wrap_pc",  PC, 32'hFFFF_FFFC);
        check("wrap_pc4", PCPlus4, 32'h0);
        do_exec(2'b00, '0, '0);
        check("wrap_next_addr", imem_addr, 32'h0);
        check("wrap_err",       {31'b0, MisalignErr}, 0);
        check("wrap_cnt",       RetireCount, 8);

        wait_valid();
        force dut.RetireCount = 32'hFFFF_FFFF;
        release dut.RetireCount;
        do_exec(2'b00, '0, '0);
        check("cnt_roll", RetireCount, 0);
        check("cnt_roll_pc", PC, 32'h4);

        do_exec(2'b10, '0, 32'h200);
        do_exec(2'b01, 32'h6, '0);
        check("mis_err",   {31'b0, MisalignErr}, 1);
        check("mis_pc",    PC, 32'h200);
        check("mis_cnt",   RetireCount, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt_req",   {31'b0, imem_req}, 0);
            check("halt_valid", {31'b0, InstrValid}, 0);
        end

        rst_n = 1'b0;
        #1;
        check("rst2_err", {31'b0, MisalignErr}, 0);
        check("rst2_pc",  PC, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;
        do_exec(2'b11, '0, 32'h302);
        check("jalr_mis_err", {31'b0, MisalignErr}, 1);
        check("jalr_mis_pc",  PC, 32'h100);

        rst_n = 1'b0;
        lat = 3;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mw_req", {31'b0, imem_req}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mw_instr_async", Instr, 32'h13);
        check("mw_valid_async", {31'b0, InstrValid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mw_refetch_req",  {31'b0, imem_req}, 1);
        check("mw_refetch_addr", imem_addr, 32'h100);
        check("mw_instr",        Instr, 32'h13);
        @(negedge clk);
        check("mw_drop_instr", Instr, 32'h13);
        check("mw_drop_valid", {31'b0, InstrValid}, 0);
        wait_valid();
        check("mw_new_instr", Instr, word(32'h100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
